// File: rtl/down_count_ctrl_pkg.sv
// Shared constants for the down-counter sequencer: state encodings and default width.
// Encoding 2'd3 is unused and recovers to IDLE.
package down_count_ctrl_pkg;

  localparam int DEF_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/down_count_ctrl_if.sv
// Host-side control strobes and status of the down-counter sequencer.
// The master modport is the host; the slave modport is the controller.
interface down_count_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             pause;
  logic             abort;
  logic             auto_reload;
  logic [WIDTH-1:0] count_out;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output start, load_val, pause, abort, auto_reload,
    input  count_out, busy, tc, done
  );

  modport slave (
    input  start, load_val, pause, abort, auto_reload,
    output count_out, busy, tc, done
  );
endinterface

// File: rtl/down_count_ctrl_core.sv
// Registered down counter: load has priority over decrement; never wraps below zero.
// Latency: one cycle from load/en to q; no backpressure.
module down_count_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             is_one
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en && (q != '0)) begin
      q <= q - WIDTH'(1);
    end
  end

  assign is_one = (q == WIDTH'(1));

endmodule

// File: rtl/down_count_ctrl.sv
// Down-counter sequencer: load, count, pause/abort, terminal-count and optional auto-reload.
// Latency: all outputs registered, one cycle after the sampled strobe; no backpressure.
module down_count_ctrl
  import down_count_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic              clk,
  input logic              reset,
  down_count_ctrl_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  logic             core_load;
  logic             core_en;
  logic [WIDTH-1:0] core_val;
  logic [WIDTH-1:0] q;
  logic             is_one;
  logic             is_zero;
  logic             tc_nxt;
  logic             done_nxt;
  logic             busy_q;
  logic             tc_q;
  logic             done_q;

  down_count_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (core_load),
    .load_val (core_val),
    .en       (core_en),
    .q        (q),
    .is_one   (is_one)
  );

  assign is_zero = (q == '0);

  always_comb begin
    state_nxt = state;
    core_load = 1'b0;
    core_val  = bus.load_val;
    core_en   = 1'b0;
    tc_nxt    = 1'b0;
    done_nxt  = 1'b0;

    if (bus.abort) begin
      state_nxt = ST_IDLE;
      core_load = 1'b1;
      core_val  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            core_load = 1'b1;
            if (bus.load_val == '0) begin
              tc_nxt   = 1'b1;
              done_nxt = 1'b1;
            end else begin
              state_nxt = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Zero while running means the reload cycle; it completes even under pause.
          if (is_zero) begin
            core_load = 1'b1;
            if (bus.load_val == '0) begin
              tc_nxt = 1'b1;
              if (!bus.auto_reload) begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
              end
            end
            if (bus.pause && (state_nxt == ST_RUN)) begin
              state_nxt = ST_HOLD;
            end
          end else if (bus.pause) begin
            state_nxt = ST_HOLD;
          end else begin
            core_en = 1'b1;
            if (is_one) begin
              tc_nxt = 1'b1;
              if (!bus.auto_reload) begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          if (!bus.pause) begin
            state_nxt = ST_RUN;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          core_load = 1'b1;
          core_val  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt == ST_RUN) || (state_nxt == ST_HOLD);
      tc_q   <= tc_nxt;
      done_q <= done_nxt;
    end
  end

  assign bus.count_out = q;
  assign bus.busy      = busy_q;
  assign bus.tc        = tc_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_down_count_ctrl.sv
// Bench for down_count_ctrl: directed vector table, hand-written corner sequences and a
// randomized run compared against an integer-level reference model.
module tb_down_count_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  down_count_ctrl_if #(.WIDTH(4)) bus ();

  down_count_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       start;
    logic [3:0] lv;
    logic       pause;
    logic       abort;
    logic       ar;
    logic [3:0] cnt;
    logic       busy;
    logic       tc;
    logic       done;
  } vec_t;

  vec_t vecs[23];

  // Reference model state: plain integers and flags.
  int   m_cnt;
  bit   m_run;
  bit   m_hold;
  bit   m_tc;
  bit   m_done;

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got cnt=%0d busy=%0b tc=%0b done=%0b, expected cnt=%0d busy=%0b tc=%0b done=%0b",
               name, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.count_out, bus.busy, bus.tc, bus.done};
  endfunction

  task automatic drive(input logic s, input logic [3:0] lv, input logic p, input logic a,
                       input logic ar);
    bus.start       = s;
    bus.load_val    = lv;
    bus.pause       = p;
    bus.abort       = a;
    bus.auto_reload = ar;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_edge(input bit s, input int lv, input bit p, input bit a, input bit ar);
    m_tc   = 0;
    m_done = 0;
    if (a) begin
      m_run = 0; m_hold = 0; m_cnt = 0;
    end else if (!m_run && !m_hold) begin
      if (s) begin
        m_cnt = lv;
        if (lv == 0) begin m_tc = 1; m_done = 1; end
        else m_run = 1;
      end
    end else if (m_hold) begin
      if (!p) begin m_hold = 0; m_run = 1; end
    end else if (m_cnt == 0) begin
      m_cnt = lv;
      if (lv == 0) begin
        m_tc = 1;
        if (!ar) begin m_run = 0; m_done = 1; end
      end
      if (m_run && p) begin m_run = 0; m_hold = 1; end
    end else if (p) begin
      m_run = 0; m_hold = 1;
    end else begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_tc = 1;
        if (!ar) begin m_run = 0; m_done = 1; end
      end
    end
  endtask

  function automatic logic [6:0] model_outs();
    logic [3:0] c;
    c = 4'(m_cnt);
    return {c, logic'(m_run || m_hold), logic'(m_tc), logic'(m_done)};
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] exp;
    bit s, p, a, ar;
    int lv;

    // start, lv, pause, abort, ar -> cnt, busy, tc, done
    vecs[0]  = '{1, 5, 0, 0, 0,  5, 1, 0, 0};
    vecs[1]  = '{0, 5, 0, 0, 0,  4, 1, 0, 0};
    vecs[2]  = '{0, 5, 0, 0, 0,  3, 1, 0, 0};
    vecs[3]  = '{0, 5, 0, 0, 0,  2, 1, 0, 0};
    vecs[4]  = '{0, 5, 0, 0, 0,  1, 1, 0, 0};
    vecs[5]  = '{0, 5, 0, 0, 0,  0, 0, 1, 1};
    vecs[6]  = '{0, 5, 0, 0, 0,  0, 0, 0, 0};
    vecs[7]  = '{1, 0, 0, 0, 0,  0, 0, 1, 1};
    vecs[8]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0};
    vecs[9]  = '{1, 7, 0, 1, 0,  0, 0, 0, 0};
    vecs[10] = '{1, 3, 0, 0, 1,  3, 1, 0, 0};
    vecs[11] = '{0, 3, 0, 0, 1,  2, 1, 0, 0};
    vecs[12] = '{0, 3, 0, 0, 1,  1, 1, 0, 0};
    vecs[13] = '{0, 3, 0, 0, 1,  0, 1, 1, 0};
    vecs[14] = '{0, 3, 0, 0, 1,  3, 1, 0, 0};
    vecs[15] = '{0, 3, 0, 0, 1,  2, 1, 0, 0};
    vecs[16] = '{0, 3, 0, 1, 1,  0, 0, 0, 0};
    vecs[17] = '{1, 2, 0, 0, 0,  2, 1, 0, 0};
    vecs[18] = '{1, 9, 0, 0, 0,  1, 1, 0, 0};
    vecs[19] = '{0, 9, 1, 0, 0,  1, 1, 0, 0};
    vecs[20] = '{0, 9, 1, 0, 0,  1, 1, 0, 0};
    vecs[21] = '{0, 9, 0, 0, 0,  1, 1, 0, 0};
    vecs[22] = '{0, 9, 0, 0, 0,  0, 0, 1, 1};

    drive(0, 0, 0, 0, 0);
    #100;
    check("reset_state", outs(), 7'b0);
    #100;
    reset = 1'b1;
    #3;
    check("after_release", outs(), 7'b0);

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].start, vecs[i].lv, vecs[i].pause, vecs[i].abort, vecs[i].ar);
      step();
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].cnt, vecs[i].busy, vecs[i].tc, vecs[i].done});
    end

    // Pause for three sampled edges at count 6, then resume with one idle edge.
    drive(1, 9, 0, 0, 0);
    step();
    for (int c = 8; c >= 6; c--) begin
      drive(0, 9, 0, 0, 0);
      step();
      check($sformatf("pause_pre_%0d", c), outs(), {4'(c), 3'b100});
    end
    drive(0, 9, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("pause_hold_%0d", k), outs(), {4'd6, 3'b100});
    end
    drive(0, 9, 0, 0, 0);
    step();
    check("pause_resume", outs(), {4'd6, 3'b100});
    for (int c = 5; c >= 1; c--) begin
      step();
      check($sformatf("pause_post_%0d", c), outs(), {4'(c), 3'b100});
    end
    step();
    check("pause_end", outs(), {4'd0, 3'b011});

    // Pause raised during the reload cycle: reload completes, then hold.
    drive(1, 2, 0, 0, 1);
    step();
    drive(0, 2, 0, 0, 1);
    step();
    step();
    check("reload_tc", outs(), {4'd0, 3'b110});
    drive(0, 2, 1, 0, 1);
    step();
    check("reload_under_pause", outs(), {4'd2, 3'b100});
    step();
    check("reload_then_hold", outs(), {4'd2, 3'b100});
    drive(0, 2, 0, 1, 0);
    step();
    check("abort_from_hold", outs(), 7'b0);

    // Asynchronous reset between edges.
    drive(1, 8, 0, 0, 0);
    step();
    drive(0, 8, 0, 0, 0);
    step();
    step();
    #3;
    reset = 1'b0;
    #1;
    check("async_reset", outs(), 7'b0);
    #2;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("idle_after_reset_%0d", k), outs(), 7'b0);
    end

    // Randomized run against the reference model.
    m_cnt = 0; m_run = 0; m_hold = 0; m_tc = 0; m_done = 0;
    ar = 0;
    for (int k = 0; k < 3000; k++) begin
      s  = ($urandom_range(0, 3) == 0);
      p  = ($urandom_range(0, 4) == 0);
      a  = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 15) == 0) ar = ~ar;
      lv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
      drive(s, 4'(lv), p, a, ar);
      model_edge(s, lv, p, a, ar);
      step();
      exp = model_outs();
      check($sformatf("rand_%0d", k), outs(), exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
